// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
//   bcd_state_e     : converter FSM states (IDLE, CONV, DONE)
//   BCD_DIGIT_MAX   : largest legal BCD digit value
//   bcd_bin_width() : minimum binary width that can hold 10**n - 1
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bcd_state_e;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  // Smallest w with 2**w > 10**n - 1. Only evaluated at elaboration.
  function automatic int bcd_bin_width(input int n);
    longint unsigned max_val;
    int w;
    max_val = 64'd1;
    for (int i = 0; i < n; i++) begin
      max_val = max_val * 64'd10;
    end
    max_val = max_val - 64'd1;
    w = 1;
    while ((64'd1 << w) <= max_val) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add step: o_result = i_acc*10 + i_digit.
// The multiply is built from two shifts so no multiplier is inferred.
// Ports:
//   i_acc    in  W  running accumulator
//   i_digit  in  4  digit to append (assumed already range-checked)
//   o_result out W  i_acc*10 + i_digit, truncated to W bits
module bcd_mac10 #(
  parameter int W = 14
) (
  input  logic [W-1:0] i_acc,
  input  logic [3:0]   i_digit,
  output logic [W-1:0] o_result
);

  logic [W-1:0] w_digit_ext;

  assign w_digit_ext = W'(i_digit);
  assign o_result    = (i_acc << 3) + (i_acc << 1) + w_digit_ext;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter, one digit per clock, MS digit first.
// Build option: define BCD2BIN_SIGNED_EN to add the bcd_sign input and make
// bin_out a BIN_W+1 bit two's complement value.
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; the producer holds valid/data until then, ready never depends on
// valid in the same cycle.
// Ports:
//   clk, reset_n  clock (rising edge), asynchronous active-low reset
//   in_valid      bcd_in (and bcd_sign) valid
//   in_ready      converter idle, accepts input
//   bcd_in        packed BCD, digit N_DIGITS-1 in the MS nibble
//   bcd_sign      (signed build only) 1 = negative
//   out_valid     result valid, held until out_ready
//   out_ready     downstream accepts result
//   bin_out       result (BIN_W bits unsigned, or BIN_W+1 bits signed)
//   bcd_err       qualified by out_valid: an input digit was > 9
//   dbg_state     current FSM state (bcd_state_e encoding)
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*N_DIGITS-1:0] bcd_in,
`ifdef BCD2BIN_SIGNED_EN
  input  logic                  bcd_sign,
  output logic [BIN_W:0]        bin_out,
`else
  output logic [BIN_W-1:0]      bin_out,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  bcd_err,
  output logic [1:0]            dbg_state
);

`ifdef BCD2BIN_SIGNED_EN
  localparam int OUT_W = BIN_W + 1;
`else
  localparam int OUT_W = BIN_W;
`endif
  localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  if (N_DIGITS < 1) begin : g_ndigits_chk
    $error("bcd_to_binary_seq: N_DIGITS must be >= 1");
  end
  if (BIN_W < bcd_bin_width(N_DIGITS)) begin : g_width_chk
    $error("bcd_to_binary_seq: BIN_W too small for N_DIGITS");
  end

  bcd_state_e            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [BIN_W-1:0]      r_acc;
  logic [4*N_DIGITS-1:0] r_bcd;
  logic                  r_sign;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [OUT_W-1:0]      r_bin;
  logic                  r_err;

  logic [4*N_DIGITS-1:0] w_bcd_shift;
  logic [3:0]            w_digit;
  logic [BIN_W-1:0]      w_mac;
  logic [OUT_W-1:0]      w_result;
  logic                  w_sign_in;

  // Current digit is selected by shifting the latched word down by 4*cnt.
  assign w_bcd_shift = r_bcd >> {r_cnt, 2'b00};
  assign w_digit     = w_bcd_shift[3:0];

  bcd_mac10 #(.W(BIN_W)) u_mac10 (
    .i_acc    (r_acc),
    .i_digit  (w_digit),
    .o_result (w_mac)
  );

`ifdef BCD2BIN_SIGNED_EN
  logic [OUT_W-1:0] w_mag;
  assign w_sign_in = bcd_sign;
  assign w_mag     = {1'b0, w_mac};
  // Negating zero gives zero, so "-0" needs no special case.
  assign w_result  = r_sign ? -w_mag : w_mag;
`else
  assign w_sign_in = 1'b0;
  assign w_result  = w_mac;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_bcd       <= '0;
      r_sign      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_bin       <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_bcd      <= bcd_in;
            r_sign     <= w_sign_in;
            r_acc      <= '0;
            r_cnt      <= CNT_W'(N_DIGITS - 1);
            r_in_ready <= 1'b0;
            r_state    <= CONV;
          end
        end
        CONV: begin
          if (w_digit > BCD_DIGIT_MAX) begin
            // Invalid digit: abort, remaining digits are not examined.
            r_err       <= 1'b1;
            r_bin       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_acc <= w_mac;
            if (r_cnt == '0) begin
              r_err       <= 1'b0;
              r_bin       <= w_result;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        DONE: begin
          // in_ready rises only after the output handshake edge, so an accept
          // can never share a cycle with a result transfer.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign bin_out   = r_bin;
  assign bcd_err   = r_err;
  assign dbg_state = r_state;

  logic w_unused;
  assign w_unused = r_sign;

endmodule
